// File: rtl/xcfi_check_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xcfi_ctrl_pkg
// Brief    : Shared types and helpers for the XCFI check-strobe controller.
// Revision : 1.0
// ============================================================================
package xcfi_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_WINDOW = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int unsigned CYCLE_W_DFLT   = 8;
    localparam int unsigned CYCLE_MAX_DFLT = (1 << CYCLE_W_DFLT) - 1;

    // Handles up to 64 lanes; callers zero-extend narrower vectors.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xcfi_check_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : xcfi_check_ctrl_if
// Brief    : Retirement trace inputs and per-channel check strobes.
// Revision : 1.0
// ============================================================================
interface xcfi_check_ctrl_if #(
    parameter int NRET    = 1,
    parameter int ORDER_W = 64
);
    logic [NRET-1:0]         rvfi_valid;
    logic [NRET*ORDER_W-1:0] rvfi_order;
    logic [NRET-1:0]         rvfi_halt;
    logic [NRET-1:0]         check;

    modport master (
        output rvfi_valid,
        output rvfi_order,
        output rvfi_halt,
        input  check
    );

    modport slave (
        input  rvfi_valid,
        input  rvfi_order,
        input  rvfi_halt,
        output check
    );
endinterface
`default_nettype wire

// File: rtl/xcfi_check_ctrl_order.sv
`default_nettype none
// ============================================================================
// Module   : xcfi_order_tracker
// Brief    : Tracks expected rvfi_order and flags lane/order discontinuities.
// Revision : 1.0
// ============================================================================
module xcfi_order_tracker
    import xcfi_ctrl_pkg::*;
#(
    parameter int NRET    = 1,
    parameter int ORDER_W = 64
) (
    input  wire logic                    clock,
    input  wire logic                    reset,
    input  wire logic [NRET-1:0]         rvfi_valid,
    input  wire logic [NRET*ORDER_W-1:0] rvfi_order,
    output logic                         order_err
);

    logic [ORDER_W-1:0] r_expected;
    logic               r_order_err;
    logic               w_mismatch;
    logic               w_contig;
    logic [ORDER_W-1:0] w_count;

    // A contiguous-from-zero mask has no set bit above its lowest clear bit.
    assign w_contig = ((rvfi_valid + 1'b1) & rvfi_valid) == '0;
    assign w_count  = ORDER_W'(popcount(64'(rvfi_valid)));

    always_comb begin
        w_mismatch = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            if (rvfi_valid[k] &&
                rvfi_order[k*ORDER_W +: ORDER_W] != r_expected + ORDER_W'(k)) begin
                w_mismatch = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_expected  <= '0;
            r_order_err <= 1'b0;
        end else begin
            r_expected <= r_expected + w_count;
            if (w_mismatch || !w_contig) begin
                r_order_err <= 1'b1;
            end
        end
    end

    assign order_err = r_order_err;

endmodule
`default_nettype wire

// File: rtl/xcfi_check_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : xcfi_check_ctrl
// Brief    : Check-window strobe and retirement sequencing controller.
//            Optional macro XCFI_HALT_STOP_EN: halting retirement ends checking.
// Revision : 1.0
// ============================================================================
module xcfi_check_ctrl
    import xcfi_ctrl_pkg::*;
#(
    parameter int NRET       = 1,
    parameter int ORDER_W    = 64,
    parameter int CYCLE_W    = CYCLE_W_DFLT,
    parameter int CHECK_LO   = 15,
    parameter int CHECK_HI   = 15,
    parameter int FIRST_ONLY = 0
) (
    input  wire logic          clock,
    input  wire logic          reset,
    xcfi_check_ctrl_if.slave   bus,
    output logic [CYCLE_W-1:0] cycle,
    output logic               window_open,
    output logic [CYCLE_W-1:0] retired,
    output logic               order_err,
    output logic               done
);

    localparam logic [CYCLE_W-1:0] c_cycle_max = '1;
    localparam logic [CYCLE_W-1:0] c_check_lo  = CYCLE_W'(CHECK_LO);
    localparam logic [CYCLE_W-1:0] c_check_hi  = CYCLE_W'(CHECK_HI);

    state_t             r_state;
    state_t             w_state_next;
    logic [CYCLE_W-1:0] r_cycle;
    logic [CYCLE_W-1:0] w_cycle_next;
    logic [CYCLE_W-1:0] r_retired;
    logic [CYCLE_W-1:0] w_retired_next;
    logic [CYCLE_W:0]   w_ret_sum;
    logic [NRET-1:0]    w_eligible;
    logic [NRET-1:0]    w_strobe;
    logic [NRET-1:0]    w_check;
    logic               w_halt_hit;

`ifdef XCFI_HALT_STOP_EN
    logic [NRET-1:0] w_halt_req;
    logic [NRET-1:0] w_halt_low;

    // Keep lanes up to and including the lowest halting lane.
    assign w_halt_req = bus.rvfi_valid & bus.rvfi_halt;
    assign w_halt_low = w_halt_req & (~w_halt_req + 1'b1);
    assign w_halt_hit = |w_halt_req;
    assign w_eligible = w_halt_hit ? (bus.rvfi_valid & (w_halt_low | (w_halt_low - 1'b1)))
                                   : bus.rvfi_valid;
`else
    logic w_unused_halt;
    assign w_unused_halt = ^bus.rvfi_halt;
    assign w_halt_hit    = 1'b0;
    assign w_eligible    = bus.rvfi_valid;
`endif

    generate
        if (FIRST_ONLY != 0) begin : g_first_only
            assign w_strobe = w_eligible & (~w_eligible + 1'b1);
        end else begin : g_all_lanes
            assign w_strobe = w_eligible;
        end
    endgenerate

    assign w_check      = (r_state == ST_WINDOW) ? w_strobe : '0;
    assign bus.check    = w_check;
    assign w_cycle_next = (r_cycle == c_cycle_max) ? r_cycle : r_cycle + 1'b1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WARMUP: begin
                if (w_cycle_next == c_check_lo) begin
                    w_state_next = ST_WINDOW;
                end
            end
            ST_WINDOW: begin
                if (w_cycle_next > c_check_hi || (FIRST_ONLY != 0 && |w_check)) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_DONE;
        endcase
        if (w_halt_hit) begin
            w_state_next = ST_DONE;
        end
    end

    assign w_ret_sum      = {1'b0, r_retired} + (CYCLE_W+1)'(popcount(64'(w_check)));
    assign w_retired_next = (w_ret_sum > {1'b0, c_cycle_max}) ? c_cycle_max
                                                              : w_ret_sum[CYCLE_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_WARMUP;
            r_cycle   <= '0;
            r_retired <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cycle   <= w_cycle_next;
            r_retired <= w_retired_next;
        end
    end

    xcfi_order_tracker #(
        .NRET    (NRET),
        .ORDER_W (ORDER_W)
    ) u_order (
        .clock      (clock),
        .reset      (reset),
        .rvfi_valid (bus.rvfi_valid),
        .rvfi_order (bus.rvfi_order),
        .order_err  (order_err)
    );

    assign cycle       = r_cycle;
    assign retired     = r_retired;
    assign window_open = (r_state == ST_WINDOW);
    assign done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_xcfi_check_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_xcfi_check_ctrl
// Brief    : Directed self-checking bench for xcfi_check_ctrl configurations.
// Revision : 1.0
// ============================================================================
module tb_xcfi_check_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    xcfi_check_ctrl_if #(.NRET(1), .ORDER_W(64)) if_a ();
    xcfi_check_ctrl_if #(.NRET(2), .ORDER_W(64)) if_b ();
    xcfi_check_ctrl_if #(.NRET(2), .ORDER_W(64)) if_c ();
    xcfi_check_ctrl_if #(.NRET(2), .ORDER_W(64)) if_d ();

    logic [7:0] cyc_a, ret_a, cyc_b, ret_b, cyc_c, ret_c, cyc_d, ret_d;
    logic       win_a, err_a, done_a, win_b, err_b, done_b;
    logic       win_c, err_c, done_c, win_d, err_d, done_d;

    xcfi_check_ctrl #(.NRET(1), .ORDER_W(64), .CYCLE_W(8), .CHECK_LO(15), .CHECK_HI(15), .FIRST_ONLY(0))
    u_a (.clock(clock), .reset(reset), .bus(if_a), .cycle(cyc_a), .window_open(win_a),
         .retired(ret_a), .order_err(err_a), .done(done_a));

    xcfi_check_ctrl #(.NRET(2), .ORDER_W(64), .CYCLE_W(8), .CHECK_LO(10), .CHECK_HI(12), .FIRST_ONLY(0))
    u_b (.clock(clock), .reset(reset), .bus(if_b), .cycle(cyc_b), .window_open(win_b),
         .retired(ret_b), .order_err(err_b), .done(done_b));

    xcfi_check_ctrl #(.NRET(2), .ORDER_W(64), .CYCLE_W(8), .CHECK_LO(5), .CHECK_HI(20), .FIRST_ONLY(1))
    u_c (.clock(clock), .reset(reset), .bus(if_c), .cycle(cyc_c), .window_open(win_c),
         .retired(ret_c), .order_err(err_c), .done(done_c));

    xcfi_check_ctrl #(.NRET(2), .ORDER_W(64), .CYCLE_W(8), .CHECK_LO(5), .CHECK_HI(30), .FIRST_ONLY(0))
    u_d (.clock(clock), .reset(reset), .bus(if_d), .cycle(cyc_d), .window_open(win_d),
         .retired(ret_d), .order_err(err_d), .done(done_d));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_inputs();
        if_a.rvfi_valid = '0; if_a.rvfi_order = '0; if_a.rvfi_halt = '0;
        if_b.rvfi_valid = '0; if_b.rvfi_order = '0; if_b.rvfi_halt = '0;
        if_c.rvfi_valid = '0; if_c.rvfi_order = '0; if_c.rvfi_halt = '0;
        if_d.rvfi_valid = '0; if_d.rvfi_order = '0; if_d.rvfi_halt = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] exp2;
        idle_inputs();
        do_reset();
        chk("rst_cycle_a", 64'(cyc_a), 64'd0);
        chk("rst_retired_b", 64'(ret_b), 64'd0);
        chk("rst_done_c", 64'(done_c), 64'd0);
        chk("rst_window_d", 64'(win_d), 64'd0);

        // Single-lane, single-cycle window at 15
        for (int c = 1; c <= 20; c++) begin
            tick();
            if_a.rvfi_valid = 1'b1;
            if_a.rvfi_order = 64'(c - 1);
            #1;
            if (c == 1 || c == 15 || c == 16) chk("a_cycle", 64'(cyc_a), 64'(c));
            chk("a_check", 64'(if_a.check), 64'(c == 15));
            if (c == 15 || c == 16) chk("a_done", 64'(done_a), 64'(c >= 16));
        end
        tick();
        chk("a_retired", 64'(ret_a), 64'd1);
        chk("a_order_err", 64'(err_a), 64'd0);

        // Dual lane, window [10,12]
        do_reset();
        for (int c = 1; c <= 15; c++) begin
            tick();
            if_b.rvfi_valid = 2'b11;
            if_b.rvfi_order = {64'(2*c - 1), 64'(2*c - 2)};
            #1;
            exp2 = (c >= 10 && c <= 12) ? 2'b11 : 2'b00;
            chk("b_check", 64'(if_b.check), 64'(exp2));
            if (c == 9 || c == 10 || c == 12 || c == 13) chk("b_window", 64'(win_b), 64'(c >= 10 && c <= 12));
        end
        tick();
        chk("b_retired", 64'(ret_b), 64'd6);
        chk("b_order_err", 64'(err_b), 64'd0);
        chk("b_done", 64'(done_b), 64'd1);

        // First-only mode, first valid retirement at cycle 8
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c >= 8) begin
                if_c.rvfi_valid = 2'b11;
                if_c.rvfi_order = {64'(2*(c - 8) + 1), 64'(2*(c - 8))};
            end else begin
                if_c.rvfi_valid = 2'b00;
                if_c.rvfi_order = '0;
            end
            #1;
            chk("c_check", 64'(if_c.check), 64'((c == 8) ? 2'b01 : 2'b00));
            if (c == 4 || c == 5) chk("c_window", 64'(win_c), 64'(c == 5));
            if (c == 8 || c == 9) chk("c_done", 64'(done_c), 64'(c == 9));
        end
        tick();
        chk("c_retired", 64'(ret_c), 64'd1);
        chk("c_order_err", 64'(err_c), 64'd0);

        // Order gap 0,1,3 on single lane
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("d_gap_err", 64'(err_a), 64'(c >= 4));
            if_a.rvfi_valid = (c <= 3);
            if_a.rvfi_order = (c == 3) ? 64'd3 : 64'(c - 1);
        end

        // Lane gap: channel 1 valid without channel 0
        do_reset();
        tick();
        chk("lane_gap_before", 64'(err_b), 64'd0);
        if_b.rvfi_valid = 2'b10;
        if_b.rvfi_order = {64'd0, 64'd0};
        tick();
        if_b.rvfi_valid = 2'b00;
        chk("lane_gap_set", 64'(err_b), 64'd1);
        tick();
        chk("lane_gap_sticky", 64'(err_b), 64'd1);

        // Reset asserted mid-window, then restart
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            tick();
            if_b.rvfi_valid = 2'b11;
            if_b.rvfi_order = {64'(2*c - 1), 64'(2*c - 2)};
        end
        #1;
        chk("e_check_pre", 64'(if_b.check), 64'(2'b11));
        chk("e_retired_pre", 64'(ret_b), 64'd2);
        reset = 1'b1;
        #1;
        chk("e_check_rst", 64'(if_b.check), 64'd0);
        chk("e_cycle_rst", 64'(cyc_b), 64'd0);
        chk("e_window_rst", 64'(win_b), 64'd0);
        chk("e_retired_rst", 64'(ret_b), 64'd0);
        chk("e_done_rst", 64'(done_b), 64'd0);
        chk("e_err_rst", 64'(err_b), 64'd0);
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            tick();
            if_b.rvfi_valid = 2'b11;
            if_b.rvfi_order = {64'(2*c - 1), 64'(2*c - 2)};
            #1;
            if (c == 1) chk("e_cycle_restart", 64'(cyc_b), 64'd1);
            if (c == 9 || c == 10) chk("e_window_reopen", 64'(win_b), 64'(c == 10));
        end
        chk("e_check_reopen", 64'(if_b.check), 64'(2'b11));

        // Halt on channel 0 at cycle 7 with channel 1 valid
        do_reset();
        for (int c = 1; c <= 31; c++) begin
            tick();
            if_d.rvfi_valid = 2'b11;
            if_d.rvfi_order = {64'(2*c - 1), 64'(2*c - 2)};
            if_d.rvfi_halt  = (c == 7) ? 2'b01 : 2'b00;
            #1;
`ifdef XCFI_HALT_STOP_EN
            exp2 = (c == 5 || c == 6) ? 2'b11 : ((c == 7) ? 2'b01 : 2'b00);
            if (c == 7 || c == 8) chk("f_done", 64'(done_d), 64'(c >= 8));
`else
            exp2 = (c >= 5 && c <= 30) ? 2'b11 : 2'b00;
            if (c == 8 || c == 30 || c == 31) chk("f_done", 64'(done_d), 64'(c >= 31));
`endif
            chk("f_check", 64'(if_d.check), 64'(exp2));
        end
        if_d.rvfi_halt = 2'b00;
        tick();
`ifdef XCFI_HALT_STOP_EN
        chk("f_retired", 64'(ret_d), 64'd5);
`else
        chk("f_retired", 64'(ret_d), 64'd52);
`endif
        chk("f_order_err", 64'(err_d), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
